// File: rtl/clk_meas_pkg.sv
// ============================================================================
// Module   : clk_meas_pkg
// Brief    : Shared types and default constants for the clock period meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMEOUT    = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W       = 27;
  localparam int DEF_TIMEOUT_MAX = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-stage input synchronizer followed by rise/fall detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// ============================================================================
// Module   : clk_period_meter
// Brief    : Measures period and high time of a slow square wave in clk_in
//            cycles. Define MEAS_AVG4_EN to report 4-sample averages.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_MAX = DEF_TIMEOUT_MAX,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_MAX - 1);

  meas_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, r_hi_cap, w_meas_p;
  logic [CNT_W-1:0] r_period, r_high_time;
  logic             r_valid, r_timeout, r_locked;
  logic             w_rise, w_fall, w_level_unused;
  logic             w_cnt_last, w_meas_done, w_to_enter;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (sig_in),
    .level  (w_level_unused),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_meas_p   = r_cnt + CNT_W'(1);
  assign w_to_enter = (w_state_nxt == TIMEOUT);

  // Saturates rather than wraps so a dead input can never alias a period.
  always_ff @(posedge clk_in) begin
    if (!reset)           r_cnt <= '0;
    else if (w_rise)      r_cnt <= '0;
    else if (!w_cnt_last) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= WAIT_FIRST;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_meas_done = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        if (w_rise)          w_state_nxt = MEASURE;
        else if (w_cnt_last) w_state_nxt = TIMEOUT;
      end
      MEASURE: begin
        if (w_rise)          w_meas_done = 1'b1;
        else if (w_cnt_last) w_state_nxt = TIMEOUT;
      end
      TIMEOUT: begin
        if (w_rise)          w_state_nxt = MEASURE;
      end
      default:               w_state_nxt = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset)                           r_hi_cap <= '0;
    else if (r_state == MEASURE && w_fall) r_hi_cap <= w_meas_p;
  end

`ifdef MEAS_AVG4_EN
  logic [CNT_W+1:0] r_sum_p, r_sum_h, w_tot_p, w_tot_h;
  logic [1:0]       r_samp;

  assign w_tot_p = r_sum_p + (CNT_W+2)'(w_meas_p);
  assign w_tot_h = r_sum_h + (CNT_W+2)'(r_hi_cap);
`endif

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_locked    <= 1'b0;
`ifdef MEAS_AVG4_EN
      r_sum_p     <= '0;
      r_sum_h     <= '0;
      r_samp      <= '0;
`endif
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= w_to_enter;
      if (w_to_enter) r_locked <= 1'b0;
`ifdef MEAS_AVG4_EN
      if (w_to_enter) begin
        r_sum_p <= '0;
        r_sum_h <= '0;
        r_samp  <= '0;
      end else if (w_meas_done) begin
        r_samp <= r_samp + 2'd1;
        if (r_samp == 2'd3) begin
          r_period    <= w_tot_p[CNT_W+1:2];
          r_high_time <= w_tot_h[CNT_W+1:2];
          r_valid     <= 1'b1;
          r_locked    <= 1'b1;
          r_sum_p     <= '0;
          r_sum_h     <= '0;
        end else begin
          r_sum_p <= w_tot_p;
          r_sum_h <= w_tot_h;
        end
      end
`else
      if (w_meas_done) begin
        r_period    <= w_meas_p;
        r_high_time <= r_hi_cap;
        r_valid     <= 1'b1;
        r_locked    <= 1'b1;
      end
`endif
    end
  end

  assign period       = r_period;
  assign high_time    = r_high_time;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;
  assign locked       = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// ============================================================================
// Module   : tb_clk_period_meter
// Brief    : Directed self-checking bench for clk_period_meter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TMAX  = 50;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, timeout, locked;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_p = 0;
  int last_h = 0;
  int to_cyc = 0;
  int v_cyc  = 0;
  bit saw_timeout = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_MAX (TMAX),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout),
    .locked       (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc_n++;
    if (period_valid === 1'b1) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc_n;
      last_p = int'(period);
      last_h = int'(high_time);
    end
    if (timeout === 1'b1) saw_timeout = 1'b1;
  endtask

  task automatic wave(input int h, input int l);
    for (int i = 0; i < h + l; i++) begin
      sig_in = (i < h);
      step();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_high"},   32'(high_time), 0);
    check({tag, "_valid"},  32'(period_valid), 0);
    check({tag, "_timeout"},32'(timeout), 0);
    check({tag, "_locked"}, 32'(locked), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b1;

`ifdef MEAS_AVG4_EN
    n_valid = 0;
    wave(5, 5);
    wave(5, 5);
    wave(5, 6);
    wave(5, 7);
    check("avg_no_early_pulse", 32'(n_valid), 0);
    check("avg_not_locked", 32'(locked), 0);
    wave(5, 5);
    check("avg_one_pulse", 32'(n_valid), 1);
    check("avg_period", 32'(last_p), 10);
    check("avg_high", 32'(last_h), 5);
    check("avg_locked", 32'(locked), 1);
    check("avg_timeout", 32'(timeout), 0);
`else
    // 10-cycle square wave, 50% duty
    n_valid = 0;
    repeat (4) wave(5, 5);
    check("sq_pulses", 32'(n_valid), 3);
    check("sq_period", 32'(last_p), 10);
    check("sq_high", 32'(last_h), 5);
    check("sq_spacing", 32'(last_valid_cyc - prev_valid_cyc), 10);
    check("sq_locked", 32'(locked), 1);

    // 25% duty wave
    n_valid = 0;
    repeat (3) wave(3, 9);
    check("duty_pulses", 32'(n_valid), 3);
    check("duty_period", 32'(last_p), 12);
    check("duty_high", 32'(last_h), 3);

    // input stops low: timeout exactly TMAX cycles after the last rise
    v_cyc  = last_valid_cyc;
    sig_in = 1'b0;
    to_cyc = 0;
    for (int i = 0; i < 200 && to_cyc == 0; i++) begin
      step();
      if (timeout === 1'b1) to_cyc = cyc_n;
    end
    check("to_delay", 32'(to_cyc - v_cyc), TMAX);
    check("to_unlocked", 32'(locked), 0);
    check("to_period_held", 32'(period), 12);
    check("to_high_held", 32'(high_time), 3);

    n_valid = 0;
    wave(5, 5);
    check("rec_timeout_clr", 32'(timeout), 0);
    check("rec_no_pulse", 32'(n_valid), 0);
    check("rec_not_locked", 32'(locked), 0);
    wave(5, 5);
    check("rec_pulse", 32'(n_valid), 1);
    check("rec_period", 32'(last_p), 10);
    check("rec_high", 32'(last_h), 5);
    check("rec_locked", 32'(locked), 1);

    // period exactly TMAX: rise wins over timeout
    n_valid = 0;
    saw_timeout = 1'b0;
    repeat (2) wave(20, 30);
    check("max_pulses", 32'(n_valid), 2);
    check("max_period", 32'(last_p), TMAX);
    check("max_high", 32'(last_h), 20);
    check("max_no_timeout", 32'(saw_timeout), 0);

    // reset pulse mid-period
    sig_in = 1'b1;
    repeat (2) step();
    sig_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_zero("midrst");
    reset = 1'b1;
    n_valid = 0;
    wave(5, 5);
    check("midrst_first_rise", 32'(n_valid), 0);
    check("midrst_not_locked", 32'(locked), 0);
    wave(5, 5);
    check("midrst_pulse", 32'(n_valid), 1);
    check("midrst_period", 32'(last_p), 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
